// File: rtl/wb_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dbg_pkg
//  Description : Shared state encoding and command/response byte values for
//                the byte-stream Wishbone debug master.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_dbg_pkg;

    // Controller states. The top owns IDLE..BUS; the transmit serializer owns
    // STAT, TXWAIT and RDATA while the top parks in STAT.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_BUS    = 3'd3;
    localparam logic [2:0] ST_STAT   = 3'd4;
    localparam logic [2:0] ST_TXWAIT = 3'd5;
    localparam logic [2:0] ST_RDATA  = 3'd6;

    // Host command opcodes ('W' and 'R').
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    // Status bytes returned to the host ('K' and 'E').
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    // True for a byte that opens a command.
    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_dbg_txser.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dbg_txser
//  Description : Sends a status byte followed optionally by the four bytes of
//                the read response (MSB first) using the tx_busy handshake.
//                Pulses done for one cycle when the last byte has drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dbg_txser
    import wb_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  status,
    input  logic [31:0] rsp_data,
    input  logic        send_data,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        done
);

    logic [2:0]  r_state;
    logic [7:0]  r_status;
    logic [31:0] r_shift;
    logic [2:0]  r_left;
    logic        r_skip;

    // Response sequencer: STAT -> TXWAIT -> (RDATA -> TXWAIT) x4 -> idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_status <= 8'h00;
            r_shift  <= 32'h0;
            r_left   <= 3'd0;
            r_skip   <= 1'b0;
            tx_data  <= 8'h00;
            tx_wr    <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_wr <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_status <= status;
                        r_shift  <= rsp_data;
                        r_left   <= send_data ? 3'd4 : 3'd0;
                        r_state  <= ST_STAT;
                    end
                end
                ST_STAT: begin
                    if (!tx_busy) begin
                        tx_data <= r_status;
                        tx_wr   <= 1'b1;
                        r_skip  <= 1'b1;
                        r_state <= ST_TXWAIT;
                    end
                end
                ST_TXWAIT: begin
                    // The transmitter raises busy only after it has seen
                    // tx_wr, so busy is meaningless during the strobe cycle.
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (!tx_busy) begin
                        if (r_left != 3'd0) begin
                            r_state <= ST_RDATA;
                        end else begin
                            r_state <= ST_IDLE;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    tx_data <= r_shift[31:24];
                    tx_wr   <= 1'b1;
                    r_shift <= {r_shift[23:0], 8'h00};
                    r_left  <= r_left - 3'd1;
                    r_skip  <= 1'b1;
                    r_state <= ST_TXWAIT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_dbg_master.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dbg_master
//  Description : Byte-stream driven Wishbone initiator. Decodes 'W'/'R'
//                commands from a UART receiver, runs one classic 32-bit bus
//                cycle and returns status (and read data) to a UART
//                transmitter.
//  Options     : WBDBG_TIMEOUT_EN - abort a bus cycle with status 'E' after
//                TIMEOUT_CYCLES cycles without ack/err.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    logic [2:0]  r_state;
    logic [1:0]  r_byte_cnt;
    logic        r_is_write;
    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rsp;
    logic [7:0]  r_status;
    logic        r_send_data;
    logic        r_start;
    logic        w_tx_done;
    logic        w_timeout;
    logic        w_ack_ok;
    logic        w_bus_end;

`ifdef WBDBG_TIMEOUT_EN
    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Cycles spent in BUS; held at zero elsewhere so each bus cycle starts at 0.
    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_BUS)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_BUS) && (r_tmo_cnt == c_tmo_last);
`else
    assign w_timeout = 1'b0;
`endif

    // Ack with err counts as err; a terminal timeout loses to a real ack.
    assign w_ack_ok  = wb_ack_i && !wb_err_i;
    assign w_bus_end = wb_ack_i || wb_err_i || w_timeout;

    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;

    // Command decode and bus-cycle control.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= 2'd0;
            r_is_write  <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 32'h0;
            r_dat       <= 32'h0;
            r_rsp       <= 32'h0;
            r_status    <= 8'h00;
            r_send_data <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_avail && is_cmd(rx_data)) begin
                        r_is_write <= (rx_data == CMD_WRITE);
                        r_byte_cnt <= 2'd0;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (rx_avail) begin
                        r_adr      <= {r_adr[23:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_BUS;
                                r_cyc   <= 1'b1;
                                r_we    <= 1'b0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_avail) begin
                        r_dat      <= {r_dat[23:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= ST_BUS;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    if (w_bus_end) begin
                        r_cyc       <= 1'b0;
                        r_we        <= 1'b0;
                        r_status    <= w_ack_ok ? RSP_OK : RSP_ERR;
                        r_send_data <= w_ack_ok && !r_is_write;
                        r_start     <= 1'b1;
                        r_state     <= ST_STAT;
                        if (w_ack_ok) begin
                            r_rsp <= wb_dat_i;
                        end
                    end
                end
                ST_STAT: begin
                    if (w_tx_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    wb_dbg_txser u_txser (
        .clk       (clk),
        .reset     (reset),
        .start     (r_start),
        .status    (r_status),
        .rsp_data  (r_rsp),
        .send_data (r_send_data),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .done      (w_tx_done)
    );

endmodule
`default_nettype wire

// File: doc/wb_dbg_master.md
Name: wb_dbg_master

Overview:
- Wishbone initiator driven by a byte stream, so a host can read and write any slave address over a serial link.
- Takes received bytes from a UART receiver, decodes read/write commands, runs single 32-bit classic Wishbone cycles, and returns status/data bytes to a UART transmitter.
- Connects to a free master port (m2) of wb_conbus_top, alongside the LM32 instruction and data masters.

Parameters:
- timeout_cycles, 1024, number of bus cycles to wait for ack before aborting; used only with WBDBG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_avail  in  1  one-cycle strobe: rx_data valid
- tx_data  out  8  byte to send
- tx_wr  out  1  one-cycle strobe: send tx_data
- tx_busy  in  1  transmitter busy
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte select, always 4'hF
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset:
  - wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o = 0; wb_sel_o = 4'hF.
  - tx_wr = 0, tx_data = 0; state = IDLE.
- Command protocol (all multi-byte fields big-endian, MSB first):
  - 0x57 'W': 4 address bytes, then 4 data bytes.
  - 0x52 'R': 4 address bytes.
  - Any other byte in IDLE is ignored.
- States: IDLE, ADDR, DATA, BUS, STAT, TXWAIT, RDATA.
- IDLE:
  - rx_avail with 'W' or 'R' → ADDR; latch we = (byte == 'W'); clear byte counter.
- ADDR:
  - Each rx_avail shifts the byte into wb_adr_o[7:0], existing bits move up by 8.
  - After the 4th byte: go to DATA if write, else BUS.
- DATA:
  - Same shifting into wb_dat_o; after the 4th byte → BUS.
- BUS:
  - cyc/stb/we asserted in the cycle after the last byte is sampled and held until ack or err.
  - Ack or err sampled in cycle N → cyc/stb/we low in N+1.
  - On ack: read data latched into a 32-bit response register.
  - Go to STAT with status 0x4B 'K' on ack, 0x45 'E' on err.
  - Ack and err together count as err.
- STAT:
  - When tx_busy = 0: tx_wr pulses for 1 cycle with the status byte, then TXWAIT.
- TXWAIT:
  - Ignores tx_busy for exactly 1 cycle after any tx_wr, then waits for tx_busy = 0.
  - Next state: RDATA if read and status 'K' and bytes remain; otherwise IDLE.
- RDATA:
  - Sends response register bytes [31:24], [23:16], [15:8], [7:0], each followed by TXWAIT.
- Bytes received while in BUS, STAT, TXWAIT or RDATA are dropped; no queuing.
- tx_wr is never asserted on two consecutive cycles.
- Reset mid-transaction: cyc/stb drop at the reset edge, any partial command is discarded, and no response byte is sent.
- Address and data are passed through unmodified; no alignment check.

Optional Feature:
- Macro: WBDBG_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments each BUS cycle.
  - When it reaches timeout_cycles - 1 with no ack/err: cyc/stb drop next cycle and status 'E' is sent.
  - An ack arriving in the same cycle as the terminal count wins ('K').
- Undefined: no counter; BUS waits indefinitely for ack or err.

Decomposition:
- Package wb_dbg_pkg:
  - State encoding.
  - Command constants CMD_WRITE = 8'h57, CMD_READ = 8'h52.
  - Response constants RSP_OK = 8'h4B, RSP_ERR = 8'h45.
- One sub-module, wb_dbg_txser:
  - Serializes a status byte plus optional 4 data bytes onto tx_data/tx_wr under the tx_busy handshake.
  - Owns the STAT, TXWAIT and RDATA sequencing.

Test Plan:
1. Write: rx 57 00 00 10 00 DE AD BE EF; slave acks after 3 cycles → one write cycle, adr = 0x00001000, dat = 0xDEADBEEF, we = 1, sel = F; tx 'K'; cyc low the cycle after ack.
2. Read: rx 52 70 00 00 04; slave returns 0x12345678 with ack → we = 0; tx 4B 12 34 56 78, each tx_wr issued only with tx_busy low.
3. Error: read with wb_err_i asserted instead of ack → tx 45 only, no data bytes; return to IDLE; a following valid 'R' command completes normally.
4. Garbage and drops:
   - rx 00 FF 41 in IDLE → no bus activity, no tx.
   - Bytes injected during BUS → ignored; the transaction completes unaffected.
5. Timeout (WBDBG_TIMEOUT_EN, timeout_cycles = 16): no ack → cyc high for exactly 16 cycles, then tx 'E'. Ack on cycle 16 → 'K'.
6. Reset mid-op:
   - Reset asserted after 2 address bytes → state IDLE, no tx; the next full command uses only freshly received bytes.
   - Reset asserted during BUS → cyc/stb low at the reset edge.
